pipelined_mantissa_adder: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor for the floating-point datapath. It replaces the fixed-width single-cycle ripple mantissa adder with a WIDTH-bit unit. The carry chain is split into STAGES registered chunks, so wide mantissas close timing. A valid/ready handshake with back-pressure lets the block sit between the alignment shifter and the normaliser. Each result carries sum, carry-out and zero flags.

---
 rtl/fp_add_pkg.sv | 21 ++
 rtl/pipelined_mantissa_adder_if.sv | 26 ++
 rtl/full_adder.sv | 11 +
 rtl/ripple_chunk_adder.sv | 30 +++
 rtl/pipelined_mantissa_adder.sv | 108 ++++++++++
 tb/tb_pipelined_mantissa_adder.sv | 239 +++++++++++++++++++++++
 6 files changed

// File: rtl/fp_add_pkg.sv
// Shared definitions for the pipelined mantissa adder: chunk geometry helpers
// and the per-stage control record (data fields are width-dependent and live per stage).
package fp_add_pkg;

    // Width-independent part of a stage record; pending A/B' bits and the
    // partial sum are sized per stage because each stage holds a different slice.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

    function automatic int unsigned chunk_hi(input int unsigned k, input int unsigned cw,
                                             input int unsigned width);
        return ((k + 1) * cw < width) ? (k + 1) * cw : width;
    endfunction

endpackage

// File: rtl/pipelined_mantissa_adder_if.sv
// Operand/result handshake bundle between alignment shifter, adder and normaliser.
interface pipelined_mantissa_adder_if #(
    parameter int unsigned WIDTH = 11
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, zero
    );
endinterface

// File: rtl/full_adder.sv
// Single-bit full-adder cell.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/ripple_chunk_adder.sv
// Combinational W-bit ripple adder built from full-adder cells.
module ripple_chunk_adder #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);
    // Carry kept as one net per bit so the chain is not a self-referencing vector.
    for (genvar i = 0; i < W; i++) begin : g_bit
        logic ci;
        logic co;
        if (i == 0) begin : g_lsb
            assign ci = c_i;
        end else begin : g_chain
            assign ci = g_bit[i-1].co;
        end
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (ci),
            .s_o (s_o[i]),
            .c_o (co)
        );
    end

    assign c_o = g_bit[W-1].co;
endmodule

// File: rtl/pipelined_mantissa_adder.sv
// WIDTH-bit add/sub whose carry chain is cut into STAGES registered chunks,
// with valid/ready flow control and sum/carry/zero results.
module pipelined_mantissa_adder
    import fp_add_pkg::*;
#(
    parameter int unsigned WIDTH  = 11,
    parameter int unsigned STAGES = 3
) (
    input logic                       clk,
    input logic                       rst_n,
    pipelined_mantissa_adder_if.slave bus
);
    localparam int unsigned CW = ceil_div(WIDTH, STAGES);

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (STAGES - 1) * CW >= WIDTH) begin : g_param_check
        $error("pipelined_mantissa_adder: WIDTH/STAGES leave an empty carry chunk");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             zero_q;

    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c0    = bus.sub ? ~bus.cin : bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * CW;
        localparam int unsigned HI = chunk_hi(k, CW, WIDTH);
        localparam int unsigned W  = HI - LO;

        logic [WIDTH-LO-1:0] a_in;
        logic [WIDTH-LO-1:0] b_in;
        logic [W-1:0]        s_chunk;
        logic [HI-1:0]       s_d;
        logic [HI-1:0]       s_q;
        logic                c_in;
        logic                c_out;
        logic                v_in;
        stage_ctl_t          ctl_q;

        // a_in/b_in hold operand bits [WIDTH-1:LO]; s_q holds completed sum bits [HI-1:0].
        if (k == 0) begin : g_head
            assign a_in = bus.a;
            assign b_in = b_eff;
            assign c_in = c0;
            assign v_in = bus.in_valid;
            assign s_d  = s_chunk;
        end else begin : g_body
            assign a_in = g_stage[k-1].g_fwd.a_q;
            assign b_in = g_stage[k-1].g_fwd.b_q;
            assign c_in = g_stage[k-1].ctl_q.carry;
            assign v_in = g_stage[k-1].ctl_q.valid;
            assign s_d  = {s_chunk, g_stage[k-1].s_q};
        end

        ripple_chunk_adder #(.W(W)) u_add (
            .a_i (a_in[W-1:0]),
            .b_i (b_in[W-1:0]),
            .c_i (c_in),
            .s_o (s_chunk),
            .c_o (c_out)
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                ctl_q <= '0;
                s_q   <= '0;
            end else if (advance) begin
                ctl_q.valid <= v_in;
                ctl_q.carry <= c_out;
                s_q         <= s_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-HI-1:0] a_q;
            logic [WIDTH-HI-1:0] b_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[WIDTH-LO-1:W];
                    b_q <= b_in[WIDTH-LO-1:W];
                end
            end
        end else begin : g_last
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    zero_q <= 1'b0;
                end else if (advance) begin
                    zero_q <= (s_d == '0);
                end
            end
        end
    end

    // The whole pipe moves together; a held result freezes every stage behind it.
    assign advance       = !g_stage[STAGES-1].ctl_q.valid || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = g_stage[STAGES-1].ctl_q.valid;
    assign bus.cout      = g_stage[STAGES-1].ctl_q.carry;
    assign bus.sum       = g_stage[STAGES-1].s_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipelined_mantissa_adder.sv
// Directed and randomised checks of pipelined_mantissa_adder in three geometries.
module tb_pipelined_mantissa_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipelined_mantissa_adder_if #(.WIDTH(11)) bus0 ();
    pipelined_mantissa_adder_if #(.WIDTH(24)) bus1 ();
    pipelined_mantissa_adder_if #(.WIDTH(24)) bus2 ();

    pipelined_mantissa_adder #(.WIDTH(11), .STAGES(3))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    pipelined_mantissa_adder #(.WIDTH(24), .STAGES(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    pipelined_mantissa_adder #(.WIDTH(24), .STAGES(24)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    task automatic drive0(input logic v, input logic [10:0] a, input logic [10:0] b,
                          input logic cin, input logic sub);
        bus0.in_valid = v;
        bus0.a        = a;
        bus0.b        = b;
        bus0.cin      = cin;
        bus0.sub      = sub;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus0.out_ready = 1'b0;
        drive0(1'b1, 11'd5, 11'd5, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (bus0.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", bus0.out_valid); end
        n_chk++; if (bus0.sum !== 11'd0) begin n_bad++; $display("FAIL reset_sum got=%0d want=0", bus0.sum); end
        n_chk++; if (bus0.cout !== 1'b0 || bus0.zero !== 1'b0) begin n_bad++; $display("FAIL reset_flags got=%b%b want=00", bus0.cout, bus0.zero); end
        n_chk++; if (bus2.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_w24_valid got=%b%b want=00", bus1.out_valid, bus2.out_valid); end
        @(negedge clk);
        drive0(1'b0, '0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        n_chk++; if (bus0.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", bus0.in_ready); end
    endtask

    task automatic test_add();
        @(negedge clk);
        bus0.out_ready = 1'b1;
        drive0(1'b1, 11'd2047, 11'd1, 1'b0, 1'b0);
        #1;
        n_chk++; if (bus0.in_ready !== 1'b1) begin n_bad++; $display("FAIL add_in_ready got=%b want=1", bus0.in_ready); end
        @(negedge clk);
        drive0(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        n_chk++; if (bus0.out_valid !== 1'b0) begin n_bad++; $display("FAIL add_lat_e1 got=%b want=0", bus0.out_valid); end
        @(negedge clk); #1;
        n_chk++; if (bus0.out_valid !== 1'b0) begin n_bad++; $display("FAIL add_lat_e2 got=%b want=0", bus0.out_valid); end
        @(negedge clk); #1;
        n_chk++; if (bus0.out_valid !== 1'b1) begin n_bad++; $display("FAIL add_lat_e3 got=%b want=1", bus0.out_valid); end
        n_chk++; if (bus0.sum !== 11'd0 || bus0.cout !== 1'b1 || bus0.zero !== 1'b1) begin
            n_bad++; $display("FAIL add_wrap got sum=%0d cout=%b zero=%b want sum=0 cout=1 zero=1", bus0.sum, bus0.cout, bus0.zero);
        end
        @(negedge clk); #1;
        n_chk++; if (bus0.out_valid !== 1'b0) begin n_bad++; $display("FAIL add_no_dup got=%b want=0", bus0.out_valid); end
    endtask

    task automatic test_sub();
        @(negedge clk);
        bus0.out_ready = 1'b1;
        drive0(1'b1, 11'd5, 11'd7, 1'b0, 1'b1);
        @(negedge clk);
        drive0(1'b1, 11'd7, 11'd5, 1'b1, 1'b1);
        @(negedge clk);
        drive0(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk); #1;
        n_chk++; if (bus0.out_valid !== 1'b1 || bus0.sum !== 11'd2046 || bus0.cout !== 1'b0 || bus0.zero !== 1'b0) begin
            n_bad++; $display("FAIL sub_borrow got v=%b sum=%0d cout=%b zero=%b want v=1 sum=2046 cout=0 zero=0",
                              bus0.out_valid, bus0.sum, bus0.cout, bus0.zero);
        end
        @(negedge clk); #1;
        n_chk++; if (bus0.out_valid !== 1'b1 || bus0.sum !== 11'd1 || bus0.cout !== 1'b1 || bus0.zero !== 1'b0) begin
            n_bad++; $display("FAIL sub_borrow_in got v=%b sum=%0d cout=%b zero=%b want v=1 sum=1 cout=1 zero=0",
                              bus0.out_valid, bus0.sum, bus0.cout, bus0.zero);
        end
    endtask

    task automatic test_back_to_back();
        int tx = 0;
        int rx = 0;
        int cyc = 0;
        while (rx < 8 && cyc < 40) begin
            @(negedge clk);
            bus0.out_ready = !(cyc == 4 || cyc == 5);
            if (tx < 8) drive0(1'b1, 11'(tx), 11'(tx), 1'b0, 1'b0);
            else        drive0(1'b0, '0, '0, 1'b0, 1'b0);
            #1;
            if (!bus0.out_ready) begin
                n_chk++; if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b1) begin
                    n_bad++; $display("FAIL b2b_stall cyc=%0d got in_ready=%b out_valid=%b want 0 1", cyc, bus0.in_ready, bus0.out_valid);
                end
            end
            if (bus0.out_valid) begin
                n_chk++; if (bus0.sum !== 11'(2 * rx) || bus0.cout !== 1'b0 || bus0.zero !== (rx == 0)) begin
                    n_bad++; $display("FAIL b2b_result idx=%0d got sum=%0d cout=%b zero=%b want sum=%0d", rx, bus0.sum, bus0.cout, bus0.zero, 2 * rx);
                end
                if (bus0.out_ready) rx++;
            end
            if (bus0.in_valid && bus0.in_ready) tx++;
            cyc++;
        end
        n_chk++; if (rx != 8) begin n_bad++; $display("FAIL b2b_timeout got=%0d results want=8", rx); end
        @(negedge clk);
        drive0(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        n_chk++; if (bus0.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_no_dup got=%b want=0", bus0.out_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus0.out_ready = 1'b1;
        drive0(1'b1, 11'd100, 11'd200, 1'b0, 1'b0);
        @(negedge clk);
        drive0(1'b1, 11'd1, 11'd2, 1'b0, 1'b0);
        @(negedge clk);
        drive0(1'b0, '0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++; if (bus0.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_stale i=%0d got=%b want=0", i, bus0.out_valid); end
            @(negedge clk);
        end
        drive0(1'b1, 11'd3, 11'd4, 1'b0, 1'b0);
        @(negedge clk);
        drive0(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        n_chk++; if (bus0.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_e1 got=%b want=0", bus0.out_valid); end
        @(negedge clk); #1;
        n_chk++; if (bus0.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_e2 got=%b want=0", bus0.out_valid); end
        @(negedge clk); #1;
        n_chk++; if (bus0.out_valid !== 1'b1 || bus0.sum !== 11'd7) begin
            n_bad++; $display("FAIL rstmid_e3 got v=%b sum=%0d want v=1 sum=7", bus0.out_valid, bus0.sum);
        end
    endtask

    task automatic test_w24_stages1();
        @(negedge clk);
        bus1.out_ready = 1'b1;
        bus1.in_valid = 1'b1; bus1.a = 24'hFFFFFF; bus1.b = 24'h000001; bus1.cin = 1'b0; bus1.sub = 1'b0;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        #1;
        n_chk++; if (bus1.out_valid !== 1'b1 || bus1.sum !== 24'd0 || bus1.cout !== 1'b1 || bus1.zero !== 1'b1) begin
            n_bad++; $display("FAIL s1_result got v=%b sum=%0h cout=%b zero=%b want v=1 sum=0 cout=1 zero=1",
                              bus1.out_valid, bus1.sum, bus1.cout, bus1.zero);
        end
        @(negedge clk); #1;
        n_chk++; if (bus1.out_valid !== 1'b0) begin n_bad++; $display("FAIL s1_no_dup got=%b want=0", bus1.out_valid); end
    endtask

    task automatic test_w24_stages24();
        int          lat = 0;
        logic [23:0] s_seen = '1;
        logic        c_seen = 1'b0;
        logic        z_seen = 1'b0;
        @(negedge clk);
        bus2.out_ready = 1'b1;
        bus2.in_valid = 1'b1; bus2.a = 24'hFFFFFF; bus2.b = 24'h000001; bus2.cin = 1'b0; bus2.sub = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            @(negedge clk);
            bus2.in_valid = 1'b0;
            #1;
            if (bus2.out_valid && lat == 0) begin
                lat = e; s_seen = bus2.sum; c_seen = bus2.cout; z_seen = bus2.zero;
            end
        end
        n_chk++; if (lat != 24) begin n_bad++; $display("FAIL s24_latency got=%0d want=24", lat); end
        n_chk++; if (s_seen !== 24'd0 || c_seen !== 1'b1 || z_seen !== 1'b1) begin
            n_bad++; $display("FAIL s24_result got sum=%0h cout=%b zero=%b want sum=0 cout=1 zero=1", s_seen, c_seen, z_seen);
        end
    endtask

    task automatic test_random();
        logic [11:0] expq[$];
        int sent = 0;
        int cyc = 0;
        int ai, bi, ci, si, tot;
        while ((sent < 10000 || expq.size() != 0) && cyc < 60000) begin
            @(negedge clk);
            bus0.out_ready = ($urandom_range(3) != 0);
            ai = int'($urandom_range(2047)); bi = int'($urandom_range(2047));
            ci = int'($urandom_range(1));    si = int'($urandom_range(1));
            if (sent < 10000 && $urandom_range(4) != 0) drive0(1'b1, 11'(ai), 11'(bi), 1'(ci), 1'(si));
            else                                         drive0(1'b0, 11'(ai), 11'(bi), 1'(ci), 1'(si));
            #1;
            if (bus0.out_valid) begin
                n_chk++;
                if (expq.size() == 0) begin
                    n_bad++; $display("FAIL rand_extra got sum=%0d with empty reference queue", bus0.sum);
                end else if ({bus0.cout, bus0.sum} !== expq[0] || bus0.zero !== (expq[0][10:0] == 11'd0)) begin
                    n_bad++; $display("FAIL rand_result got cout=%b sum=%0d zero=%b want cout=%b sum=%0d",
                                      bus0.cout, bus0.sum, bus0.zero, expq[0][11], expq[0][10:0]);
                end
                if (bus0.out_ready && expq.size() != 0) void'(expq.pop_front());
            end
            if (bus0.in_valid && bus0.in_ready) begin
                if (si != 0) begin
                    tot = ai - bi - ci;
                    expq.push_back({tot >= 0, 11'(tot)});
                end else begin
                    tot = ai + bi + ci;
                    expq.push_back({tot >= 2048, 11'(tot)});
                end
                sent++;
            end
            cyc++;
        end
        n_chk++; if (sent != 10000 || expq.size() != 0) begin
            n_bad++; $display("FAIL rand_timeout got sent=%0d pending=%0d want 10000 0", sent, expq.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive0(1'b0, '0, '0, 1'b0, 1'b0);
        bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.sub = 1'b0; bus2.out_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        test_w24_stages1();
        test_w24_stages24();
        test_random();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
